// File: rtl/isa_io_cycle_engine_if.sv
// rtl/isa_io_cycle_engine_if.sv - ISA riser I/O bus signals driven by the cycle engine
interface isa_io_cycle_engine_if;
    logic [15:0] isa_sa;
    logic [15:0] isa_sd_out;
    logic        isa_sd_oe;
    logic [15:0] isa_sd_in;
    logic        isa_ior_n;
    logic        isa_iow_n;
    logic        isa_aen;
    logic        isa_sbhe_n;
    logic        isa_iochrdy;

    modport master (
        output isa_sa,
        output isa_sd_out,
        output isa_sd_oe,
        input  isa_sd_in,
        output isa_ior_n,
        output isa_iow_n,
        output isa_aen,
        output isa_sbhe_n,
        input  isa_iochrdy
    );

    modport slave (
        input  isa_sa,
        input  isa_sd_out,
        input  isa_sd_oe,
        output isa_sd_in,
        input  isa_ior_n,
        input  isa_iow_n,
        input  isa_aen,
        input  isa_sbhe_n,
        output isa_iochrdy
    );
endinterface

// File: rtl/isa_io_cycle_engine.sv
// rtl/isa_io_cycle_engine.sv - runs one 8/16-bit ISA I/O read or write cycle with programmable timing
module isa_io_cycle_engine #(
    parameter int SETUP_CYCLES   = 4,
    parameter int STROBE_CYCLES  = 12,
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [15:0]                 address_in,
    input  logic [15:0]                 data_in,
    input  logic [7:0]                  control_in,
    output logic [15:0]                 data_bus_out,
    output logic [7:0]                  status_out,
    isa_io_cycle_engine_if.master       isa
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        WAIT,
        HOLD
    } state_t;

    // The WAIT state always contributes at least one strobe cycle, so STROBE counts one fewer.
    localparam logic [15:0] SETUP_LOAD   = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] STROBE_LOAD  = 16'(STROBE_CYCLES - 2);
    localparam logic [15:0] HOLD_LOAD    = 16'(HOLD_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [31:0] wait_cnt;
    logic [1:0]  ctrl_prev;
    logic        wr_edge;
    logic        rd_edge;
    logic        rdy_s1;
    logic        rdy_s2;
    logic        is_read;
    logic        is_wide;
    logic        busy;
    logic        done;
    logic        timeout_flag;
    logic        unused_ctrl;

    assign unused_ctrl = &{1'b0, control_in[7:3]};
    assign status_out  = {5'b0, timeout_flag, done, busy};

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            wait_cnt       <= '0;
            ctrl_prev      <= '0;
            wr_edge        <= 1'b0;
            rd_edge        <= 1'b0;
            rdy_s1         <= 1'b0;
            rdy_s2         <= 1'b0;
            is_read        <= 1'b0;
            is_wide        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout_flag   <= 1'b0;
            data_bus_out   <= '0;
            isa.isa_sa     <= '0;
            isa.isa_sd_out <= '0;
            isa.isa_sd_oe  <= 1'b0;
            isa.isa_ior_n  <= 1'b1;
            isa.isa_iow_n  <= 1'b1;
            isa.isa_aen    <= 1'b1;
            isa.isa_sbhe_n <= 1'b1;
        end else begin
            ctrl_prev <= control_in[1:0];
            wr_edge   <= control_in[0] & ~ctrl_prev[0];
            rd_edge   <= control_in[1] & ~ctrl_prev[1];
            rdy_s1    <= isa.isa_iochrdy;
            rdy_s2    <= rdy_s1;

            case (state)
                IDLE: begin
                    // Simultaneous read and write edges are ambiguous and are dropped.
                    if (wr_edge ^ rd_edge) begin
                        state          <= SETUP;
                        cnt            <= SETUP_LOAD;
                        is_read        <= rd_edge;
                        is_wide        <= control_in[2];
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        timeout_flag   <= 1'b0;
                        isa.isa_sa     <= address_in;
                        isa.isa_aen    <= 1'b0;
                        isa.isa_sbhe_n <= ~control_in[2];
                        if (wr_edge) begin
                            isa.isa_sd_out <= data_in;
                            isa.isa_sd_oe  <= 1'b1;
                        end
                    end
                end

                SETUP: begin
                    if (cnt == 16'd0) begin
                        state <= STROBE;
                        cnt   <= STROBE_LOAD;
                        if (is_read) begin
                            isa.isa_ior_n <= 1'b0;
                        end else begin
                            isa.isa_iow_n <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end

                STROBE: begin
                    if (cnt == 16'd0) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end

                WAIT: begin
                    if (rdy_s2) begin
                        state         <= HOLD;
                        cnt           <= HOLD_LOAD;
                        isa.isa_ior_n <= 1'b1;
                        isa.isa_iow_n <= 1'b1;
                        if (is_read) begin
                            data_bus_out <= is_wide ? isa.isa_sd_in : {8'h00, isa.isa_sd_in[7:0]};
                        end
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        state         <= HOLD;
                        cnt           <= HOLD_LOAD;
                        timeout_flag  <= 1'b1;
                        isa.isa_ior_n <= 1'b1;
                        isa.isa_iow_n <= 1'b1;
                        if (is_read) begin
                            data_bus_out <= 16'hFFFF;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end

                HOLD: begin
                    if (cnt == 16'd0) begin
                        state          <= IDLE;
                        isa.isa_aen    <= 1'b1;
                        isa.isa_sd_oe  <= 1'b0;
                        isa.isa_sbhe_n <= 1'b1;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_isa_io_cycle_engine.sv
// tb/tb_isa_io_cycle_engine.sv - directed self-checking bench for isa_io_cycle_engine
module tb_isa_io_cycle_engine;
    localparam int S  = 4;
    localparam int T  = 12;
    localparam int H  = 4;
    localparam int TO = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address_in;
    logic [15:0] data_in;
    logic [7:0]  control_in;
    logic [15:0] data_bus_out;
    logic [7:0]  status_out;

    isa_io_cycle_engine_if bus();

    isa_io_cycle_engine #(
        .SETUP_CYCLES  (S),
        .STROBE_CYCLES (T),
        .HOLD_CYCLES   (H),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address_in  (address_in),
        .data_in     (data_in),
        .control_in  (control_in),
        .data_bus_out(data_bus_out),
        .status_out  (status_out),
        .isa         (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        ior_h  [0:1099];
    logic        iow_h  [0:1099];
    logic        aen_h  [0:1099];
    logic        oe_h   [0:1099];
    logic        sbhe_h [0:1099];
    logic [15:0] sa_h   [0:1099];
    logic [15:0] sdo_h  [0:1099];
    logic [15:0] dbo_h  [0:1099];
    logic [7:0]  st_h   [0:1099];

    int n_iow_low, n_ior_low, n_oe_high, n_aen_low, n_busy, iow_pulses, first_low, done_idx;
    int ctl_k1, ctl_k2, rdy_lo, rdy_hi, rst_k;
    logic [7:0]  ctl_v1, ctl_v2;
    logic [15:0] sd_alt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_plan;
        ctl_k1 = 0; ctl_k2 = 0; ctl_v1 = 8'h00; ctl_v2 = 8'h00;
        rdy_lo = 0; rdy_hi = 0; rst_k = 0; sd_alt = 16'h0000;
    endtask

    task automatic start(input logic [15:0] addr, input logic [15:0] data, input logic [7:0] ctl);
        control_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        address_in = addr;
        data_in    = data;
        control_in = ctl;
    endtask

    // Sample k is taken 1 time unit after the k-th rising edge following the control change.
    task automatic observe(input int n);
        logic prev_iow;
        bit   seen_busy;
        prev_iow = 1'b1; seen_busy = 1'b0;
        n_iow_low = 0; n_ior_low = 0; n_oe_high = 0; n_aen_low = 0;
        n_busy = 0; iow_pulses = 0; first_low = 0; done_idx = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            ior_h[k] = bus.isa_ior_n; iow_h[k] = bus.isa_iow_n; aen_h[k] = bus.isa_aen;
            oe_h[k] = bus.isa_sd_oe; sbhe_h[k] = bus.isa_sbhe_n; sa_h[k] = bus.isa_sa;
            sdo_h[k] = bus.isa_sd_out; dbo_h[k] = data_bus_out; st_h[k] = status_out;
            if (!bus.isa_iow_n) begin
                n_iow_low++;
                if (prev_iow) iow_pulses++;
            end
            prev_iow = bus.isa_iow_n;
            if (!bus.isa_ior_n) n_ior_low++;
            if ((!bus.isa_ior_n || !bus.isa_iow_n) && first_low == 0) first_low = k;
            if (bus.isa_sd_oe) n_oe_high++;
            if (!bus.isa_aen) n_aen_low++;
            if (status_out[0]) begin
                n_busy++;
                seen_busy = 1'b1;
            end else if (seen_busy && status_out[1] && done_idx == 0) begin
                done_idx = k;
            end
            if (k == ctl_k1) control_in = ctl_v1;
            if (k == ctl_k2) control_in = ctl_v2;
            bus.isa_iochrdy = !(k >= rdy_lo && k < rdy_hi);
            if (k == rdy_hi) bus.isa_sd_in = sd_alt;
            if (k == rst_k) reset = 1'b1;
            else if (rst_k != 0 && k == rst_k + 1) reset = 1'b0;
        end
        bus.isa_iochrdy = 1'b1;
    endtask

    function automatic int window_errs(input int lo, input int hi, input logic [15:0] addr,
                                       input logic [15:0] data, input bit wr);
        int e = 0;
        for (int k = lo; k <= hi; k++) begin
            if (sa_h[k] !== addr || aen_h[k] !== 1'b0) e++;
            if (wr && (sdo_h[k] !== data || oe_h[k] !== 1'b1)) e++;
        end
        return e;
    endfunction

    initial begin
        reset = 1'b1; address_in = '0; data_in = '0; control_in = '0;
        bus.isa_sd_in = 16'h0000; bus.isa_iochrdy = 1'b1;
        clear_plan();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ior_n", bus.isa_ior_n, 1);
        chk("rst_iow_n", bus.isa_iow_n, 1);
        chk("rst_aen", bus.isa_aen, 1);
        chk("rst_sbhe_n", bus.isa_sbhe_n, 1);
        chk("rst_sd_oe", bus.isa_sd_oe, 0);
        chk("rst_sa", bus.isa_sa, 16'h0000);
        chk("rst_sd_out", bus.isa_sd_out, 16'h0000);
        chk("rst_data_bus", data_bus_out, 16'h0000);
        chk("rst_status", status_out, 8'h00);
        reset = 1'b0;

        // 16-bit write
        start(16'h0220, 16'hBEEF, 8'h05);
        observe(30);
        chk("wr16_iow_low", n_iow_low, T);
        chk("wr16_ior_low", n_ior_low, 0);
        chk("wr16_first_low", first_low, 1 + 1 + S);
        chk("wr16_done_idx", done_idx, 1 + 1 + S + T + H);
        chk("wr16_sbhe", sbhe_h[6], 0);
        chk("wr16_window", window_errs(2, 21, 16'h0220, 16'hBEEF, 1'b1), 0);
        chk("wr16_status_busy", st_h[2], 8'h01);
        chk("wr16_end_aen", aen_h[22], 1);
        chk("wr16_end_oe", oe_h[22], 0);
        chk("wr16_end_sbhe", sbhe_h[22], 1);
        chk("wr16_end_status", st_h[22], 8'h02);
        chk("wr16_sa_kept", sa_h[30], 16'h0220);

        // 8-bit read
        bus.isa_sd_in = 16'hA55A;
        start(16'h0300, 16'h0000, 8'h02);
        observe(30);
        chk("rd8_ior_low", n_ior_low, T);
        chk("rd8_iow_low", n_iow_low, 0);
        chk("rd8_oe_never", n_oe_high, 0);
        chk("rd8_sbhe", sbhe_h[6], 1);
        chk("rd8_data", dbo_h[22], 16'h005A);
        chk("rd8_status", st_h[22], 8'h02);
        chk("rd8_window", window_errs(2, 21, 16'h0300, 16'h0000, 1'b0), 0);

        // 16-bit read
        bus.isa_sd_in = 16'h1234;
        start(16'h0280, 16'h0000, 8'h06);
        observe(30);
        chk("rd16_sbhe", sbhe_h[6], 0);
        chk("rd16_data", dbo_h[22], 16'h1234);
        chk("rd16_done_idx", done_idx, 22);

        // Wait states: ready low for 30 cycles after strobe starts, data changes as ready returns
        bus.isa_sd_in = 16'hDEAD;
        clear_plan();
        rdy_lo = 6; rdy_hi = 36; sd_alt = 16'h4321;
        start(16'h0310, 16'h0000, 8'h06);
        observe(50);
        chk("wait_ior_low", n_ior_low, 33);
        chk("wait_done_idx", done_idx, 43);
        chk("wait_data", dbo_h[43], 16'h4321);
        chk("wait_status", st_h[43], 8'h02);

        // Timeout: ready never returns
        clear_plan();
        rdy_lo = 1; rdy_hi = 2000;
        start(16'h0320, 16'h0000, 8'h02);
        observe(1060);
        chk("to_ior_low", n_ior_low, (T - 1) + TO);
        chk("to_done_idx", done_idx, 1 + 1 + S + (T - 1) + TO + H);
        chk("to_data", dbo_h[1045], 16'hFFFF);
        chk("to_status", st_h[1045], 8'h06);
        chk("to_ior_released", ior_h[1045], 1);
        chk("to_aen_released", aen_h[1045], 1);

        // Second write edge while busy is dropped
        clear_plan();
        ctl_k1 = 10; ctl_v1 = 8'h00; ctl_k2 = 11; ctl_v2 = 8'h05;
        start(16'h0330, 16'h5AA5, 8'h05);
        observe(40);
        chk("busy_edge_pulses", iow_pulses, 1);
        chk("busy_edge_iow_low", n_iow_low, T);
        chk("busy_edge_done_idx", done_idx, 22);
        chk("busy_edge_to_cleared", st_h[2], 8'h01);

        // Both edges at once: no activity, done stays sticky
        clear_plan();
        start(16'h0340, 16'h0000, 8'h03);
        observe(30);
        chk("both_busy", n_busy, 0);
        chk("both_aen", n_aen_low, 0);
        chk("both_strobes", n_ior_low + n_iow_low, 0);
        chk("both_status", st_h[30], 8'h02);

        // Reset during strobe
        clear_plan();
        rst_k = 10; ctl_k1 = 11; ctl_v1 = 8'h00;
        start(16'h0350, 16'h7777, 8'h05);
        observe(20);
        chk("rstmid_was_low", iow_h[10], 0);
        chk("rstmid_iow", iow_h[11], 1);
        chk("rstmid_ior", ior_h[11], 1);
        chk("rstmid_aen", aen_h[11], 1);
        chk("rstmid_oe", oe_h[11], 0);
        chk("rstmid_status", st_h[11], 8'h00);
        chk("rstmid_sa", sa_h[11], 16'h0000);
        chk("rstmid_iow_low", n_iow_low, 5);

        // Normal 8-bit write after reset
        clear_plan();
        start(16'h0388, 16'h1357, 8'h01);
        observe(30);
        chk("post_iow_low", n_iow_low, T);
        chk("post_done_idx", done_idx, 22);
        chk("post_sbhe", sbhe_h[6], 1);
        chk("post_window", window_errs(2, 21, 16'h0388, 16'h1357, 1'b1), 0);
        chk("post_status", st_h[22], 8'h02);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/isa_io_cycle_engine.md
Name: isa_io_cycle_engine

Overview:
- ISA-side bus engine; consumes the HPS register-file outputs (address, write data, control byte) and runs one 8/16-bit ISA I/O read or write cycle on the riser bus.
- Drives the control strobes with programmable setup/strobe/hold timing and honours IOCHRDY wait states.
- Returns captured read data plus busy/done/timeout status for the register file to latch back to the HPS.

Parameters:
- SETUP_CYCLES, 4, clk cycles address/AEN valid before strobe asserts (min 1)
- STROBE_CYCLES, 12, minimum clk cycles IOR#/IOW# held low (min 2)
- HOLD_CYCLES, 4, clk cycles address/data held after strobe deasserts (min 1)
- TIMEOUT_CYCLES, 1024, max cycles IOCHRDY may stay low before abort

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- address_in  in  16  I/O address from register file
- data_in  in  16  write data from register file
- control_in  in  8  [0]=start write, [1]=start read, [2]=16-bit width, others reserved
- data_bus_out  out  16  captured read data to register file
- status_out  out  8  [0]=busy, [1]=done, [2]=timeout, others 0
- isa_sa  out  16  ISA address
- isa_sd_out  out  16  ISA data out
- isa_sd_oe  out  1  data output enable (1 = drive SD)
- isa_sd_in  in  16  ISA data in
- isa_ior_n  out  1  I/O read strobe, active-low
- isa_iow_n  out  1  I/O write strobe, active-low
- isa_aen  out  1  address enable; 0 during engine cycles
- isa_sbhe_n  out  1  byte-high enable, active-low
- isa_iochrdy  in  1  asynchronous ready; 0 = insert wait

Behaviour:
- Reset values:
  - isa_ior_n=1, isa_iow_n=1, isa_aen=1, isa_sbhe_n=1, isa_sd_oe=0
  - isa_sa=0, isa_sd_out=0, data_bus_out=0, status_out=0
  - FSM in IDLE; edge-detect history cleared.
- Start detection:
  - Rising edge of control_in[0] or [1], registered one cycle.
  - Accepted only in IDLE; edges while busy are dropped, not queued.
  - Both edges in the same cycle: ignored, no state change.
- On accept:
  - Latch address_in, data_in, control_in[2], and direction.
  - Clear done and timeout; set busy.
- isa_iochrdy passes through a 2-flop synchronizer before use.
- FSM:
  - IDLE -> SETUP on accept.
  - SETUP:
    - isa_sa=latched address, isa_aen=0, isa_sbhe_n=~wide.
    - Write: isa_sd_oe=1, isa_sd_out=latched data.
    - Stay SETUP_CYCLES cycles -> STROBE.
  - STROBE: assert ior_n or iow_n low; count STROBE_CYCLES -> WAIT.
  - WAIT:
    - Strobe still low.
    - Synchronized ready=1 -> HOLD, same cycle as the ready observation.
    - Read: capture isa_sd_in into data_bus_out on the WAIT exit cycle; 8-bit reads zero-extend [7:0].
    - Ready low for TIMEOUT_CYCLES -> HOLD with timeout=1; read data forced to 16'hFFFF.
  - HOLD:
    - Strobe deasserted; address, sd_out and sd_oe held.
    - After HOLD_CYCLES -> IDLE.
    - On exit: aen=1, sd_oe=0, sbhe_n=1, busy=0, done=1.
- Status and outputs:
  - done and timeout are sticky until the next accepted start or reset.
  - isa_sa keeps its last value in IDLE.
  - All ISA outputs are registered; no glitching.
- Latency: ready held high, no waits -> busy for 1+SETUP+STROBE+HOLD cycles after the start edge is registered.
- reset asserted mid-cycle: strobes deassert and sd_oe drops on the next edge; all outputs return to reset values.

Test Plan:
- Write, 16-bit:
  - Stimulus: address_in=0x0220, data_in=0xBEEF, control_in 0x00->0x05, iochrdy=1.
  - Required: iow_n low for exactly 12 cycles; sa=0x0220 and sd_out=0xBEEF stable from 4 cycles before strobe to 4 after; sbhe_n=0; done=1, busy=0 after 21 cycles.
- Read, 8-bit:
  - Stimulus: control 0x00->0x02, isa_sd_in=0xA55A.
  - Required: ior_n low 12 cycles, sd_oe stays 0, sbhe_n=1, data_bus_out=0x005A, done=1.
- Wait states: read with iochrdy low for 30 cycles after strobe starts -> strobe extends to ~30+2 sync cycles; data captured after ready returns; timeout=0.
- Timeout: iochrdy held 0 -> abort after 1024 wait cycles; timeout=1, data_bus_out=0xFFFF, strobes released, done=1.
- Start while busy or both edges at once:
  - Second write edge mid-cycle -> ignored; only one iow_n pulse.
  - control 0x00->0x03 in IDLE -> no bus activity, busy stays 0.
- Reset mid-strobe: assert reset during STROBE -> next edge ior_n=1, aen=1, sd_oe=0, status_out=0; a following normal write completes correctly.
